// File: rtl/clk_rst_seq_pkg.sv
// Shared definitions for the clock/reset start-up sequencer.
package clk_rst_seq_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      S_RESET     = 2'd0,
      S_WAIT_LOCK = 2'd1,
      S_SETTLE    = 2'd2,
      S_RUN       = 2'd3
   } state_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/clk_rst_seq_sync2.sv
// Two-flop synchroniser for asynchronous level inputs; both stages clear to 0 in reset.
module clk_rst_seq_sync2 #(
   parameter int WIDTH = 1
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic [WIDTH-1:0] async_i,
   output logic [WIDTH-1:0] sync_o
);

   logic [WIDTH-1:0] meta_reg;
   logic [WIDTH-1:0] sync_reg;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         always_ff @(posedge clk_i) begin
            if (!rst_n_i) begin
               meta_reg[gi] <= 1'b0;
               sync_reg[gi] <= 1'b0;
            end else begin
               meta_reg[gi] <= async_i[gi];
               sync_reg[gi] <= meta_reg[gi];
            end
         end
      end
   endgenerate

   assign sync_o = sync_reg;

endmodule

// File: rtl/clk_rst_seq.sv
// PLL start-up sequencer: PLL reset stretch, lock wait with timeout/retry, settle, then
// downstream reset release plus a runtime-programmable divided tick/phase.
module clk_rst_seq
   import clk_rst_seq_pkg::*;
#(
   parameter int RST_STRETCH   = 16,
   parameter int LOCK_TIMEOUT  = 65535,
   parameter int SETTLE_CYCLES = 1024,
   parameter int DIV_W         = 16,
   parameter int DIV_INIT      = 8
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               pll_lock_i,
   output logic               pll_resetb_o,
   output logic               rst_n_o,
   input  logic [DIV_W-1:0]   div_i,
   input  logic               div_req_i,
   output logic               div_ack_o,
   output logic               tick_o,
   output logic               phase_o,
   output logic [STATE_W-1:0] state_o,
   output logic               err_o
);

   localparam int CNT_W = $clog2(max3(RST_STRETCH, LOCK_TIMEOUT, SETTLE_CYCLES) + 1);
   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
   localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(RST_STRETCH - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [DIV_W-1:0] DIV_ONE      = DIV_W'(1);
   localparam logic [DIV_W-1:0] DIV_RESET    = DIV_W'(DIV_INIT);

   logic             lock_s;
   state_t           state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             pll_resetb_reg;
   logic             rst_n_reg;
   logic             err_reg;

   logic [DIV_W-1:0] div_reg;
   logic [DIV_W-1:0] div_pend_reg;
   logic [DIV_W-1:0] ctr_reg;
   logic             pend_reg;
   logic             ack_reg;
   logic             tick_reg;
   logic             phase_reg;
   logic             run_stay;
   logic             terminal;

   clk_rst_seq_sync2 #(.WIDTH(1)) u_lock_sync (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .async_i (pll_lock_i),
      .sync_o  (lock_s)
   );

   // Outputs are registered alongside the state so they change on the transition edge.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_reg      <= S_RESET;
         cnt_reg        <= '0;
         pll_resetb_reg <= 1'b0;
         rst_n_reg      <= 1'b0;
         err_reg        <= 1'b0;
      end else begin
         case (state_reg)
            S_RESET: begin
               if (cnt_reg == STRETCH_LAST) begin
                  state_reg      <= S_WAIT_LOCK;
                  cnt_reg        <= '0;
                  pll_resetb_reg <= 1'b1;
               end else begin
                  cnt_reg <= cnt_reg + CNT_ONE;
               end
            end
            S_WAIT_LOCK: begin
               if (lock_s) begin
                  state_reg <= S_SETTLE;
                  cnt_reg   <= '0;
               end else if (cnt_reg == TIMEOUT_LAST) begin
                  state_reg      <= S_RESET;
                  cnt_reg        <= '0;
                  pll_resetb_reg <= 1'b0;
                  err_reg        <= 1'b1;
               end else begin
                  cnt_reg <= cnt_reg + CNT_ONE;
               end
            end
            S_SETTLE: begin
               if (!lock_s) begin
                  state_reg      <= S_RESET;
                  cnt_reg        <= '0;
                  pll_resetb_reg <= 1'b0;
               end else if (cnt_reg == SETTLE_LAST) begin
                  state_reg <= S_RUN;
                  cnt_reg   <= '0;
                  rst_n_reg <= 1'b1;
               end else begin
                  cnt_reg <= cnt_reg + CNT_ONE;
               end
            end
            S_RUN: begin
               if (!lock_s) begin
                  state_reg      <= S_RESET;
                  cnt_reg        <= '0;
                  pll_resetb_reg <= 1'b0;
                  rst_n_reg      <= 1'b0;
               end
            end
            default: begin
               state_reg      <= S_RESET;
               cnt_reg        <= '0;
               pll_resetb_reg <= 1'b0;
               rst_n_reg      <= 1'b0;
            end
         endcase
      end
   end

   // A lock-loss edge in S_RUN suppresses the tick and defers any pending divisor by one cycle.
   assign run_stay = (state_reg == S_RUN) && lock_s;
   assign terminal = (ctr_reg == (div_reg - DIV_ONE));

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         div_reg      <= DIV_RESET;
         div_pend_reg <= '0;
         ctr_reg      <= '0;
         pend_reg     <= 1'b0;
         ack_reg      <= 1'b0;
         tick_reg     <= 1'b0;
         phase_reg    <= 1'b0;
      end else begin
         ack_reg  <= 1'b0;
         tick_reg <= 1'b0;
         if (run_stay) begin
            if (terminal) begin
               tick_reg  <= 1'b1;
               phase_reg <= ~phase_reg;
               ctr_reg   <= '0;
               if (pend_reg) begin
                  div_reg  <= div_pend_reg;
                  pend_reg <= 1'b0;
                  ack_reg  <= 1'b1;
               end
            end else begin
               ctr_reg <= ctr_reg + DIV_ONE;
            end
         end else begin
            ctr_reg   <= '0;
            phase_reg <= 1'b0;
            if (pend_reg && (state_reg != S_RUN)) begin
               div_reg  <= div_pend_reg;
               pend_reg <= 1'b0;
               ack_reg  <= 1'b1;
            end
         end
         // Capture only when idle; apply above requires pend_reg=1, so the two never collide.
         if (div_req_i && !pend_reg && !ack_reg) begin
            div_pend_reg <= (div_i == '0) ? DIV_ONE : div_i;
            pend_reg     <= 1'b1;
         end
      end
   end

   assign pll_resetb_o = pll_resetb_reg;
   assign rst_n_o      = rst_n_reg;
   assign err_o        = err_reg;
   assign state_o      = state_reg;
   assign div_ack_o    = ack_reg;
   assign tick_o       = tick_reg;
   assign phase_o      = phase_reg;

endmodule
